// File: rtl/imem_uart_loader.sv
// UART boot loader: receives an 8N1 byte stream (16-bit word count, then big-endian
// 32-bit words) and writes the words into instruction memory while holding Loading high.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RxD,
    output logic                  WrEn,
    output logic [ADDR_WIDTH-1:0] WrAddr,
    output logic [31:0]           WrData,
    output logic                  Loading,
    output logic                  Done,
    output logic                  FrameErr,
    output logic                  LenErr,
    output logic [ADDR_WIDTH:0]   WordCount
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [16:0]         MAX_WORDS = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] WC_ONE    = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERROR} state_t;

    rx_state_t rx_state, rx_next;
    state_t    state, state_next;

    logic                  rx_meta, rx_sync;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  byte_valid;
    logic                  frame_bad;

    logic [7:0]            n_hi;
    logic [ADDR_WIDTH:0]   n_words;
    logic [23:0]           word_buf;
    logic [1:0]            byte_idx;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  frame_err;
    logic                  len_err;

    logic [15:0]           hdr_count;
    logic                  len_bad;
    logic [ADDR_WIDTH:0]   word_count_inc;

    assign hdr_count      = {n_hi, shift};
    assign len_bad        = {1'b0, hdr_count} > MAX_WORDS;
    assign word_count_inc = word_count + WC_ONE;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_state <= RX_IDLE;
            state    <= HDR_HI;
        end else begin
            rx_state <= rx_next;
            state    <= state_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_BITS;
            RX_BITS:  if (cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receiver datapath; the byte/frame strobes land on the edge that samples the stop bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            rx_meta    <= RxD;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + CNT_ONE;
                RX_BITS: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        byte_valid <= rx_sync;
                        frame_bad  <= !rx_sync;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (byte_valid) state_next = HDR_LO;
            HDR_LO: begin
                if (byte_valid) begin
                    if (len_bad)
                        state_next = ERROR;
                    else if (hdr_count == 16'd0)
                        state_next = DONE;
                    else
                        state_next = DATA;
                end
            end
            DATA:    if (wr_en && word_count_inc == n_words) state_next = DONE;
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
        if (frame_bad && (state == HDR_HI || state == HDR_LO || state == DATA))
            state_next = ERROR;
    end

    // The write strobe is raised the edge after a word's 4th byte arrives; the count advances after it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            n_hi       <= '0;
            n_words    <= '0;
            word_buf   <= '0;
            byte_idx   <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            word_count <= '0;
            frame_err  <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                HDR_HI: if (byte_valid) n_hi <= shift;
                HDR_LO: begin
                    if (byte_valid) begin
                        n_words <= hdr_count[ADDR_WIDTH:0];
                        if (len_bad) len_err <= 1'b1;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        word_buf <= {word_buf[15:0], shift};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_data <= {word_buf, shift};
                        end
                    end
                    if (wr_en) word_count <= word_count_inc;
                end
                default: ;
            endcase
            if (frame_bad && (state == HDR_HI || state == HDR_LO || state == DATA))
                frame_err <= 1'b1;
        end
    end

    assign WrEn      = wr_en;
    assign WrAddr    = word_count[ADDR_WIDTH-1:0];
    assign WrData    = wr_data;
    assign Loading   = (state != DONE);
    assign Done      = (state == DONE);
    assign FrameErr  = frame_err;
    assign LenErr    = len_err;
    assign WordCount = word_count;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: drives UART frames and logs every write-port pulse
// with its cycle number so address, data, width and latency can be checked.
module tb_imem_uart_loader;

    localparam int C  = 16;
    localparam int AW = 3;
    localparam int WR_LAT = 156;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          RxD = 1'b1;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [31:0]   WrData;
    logic          Loading, Done, FrameErr, LenErr;
    logic [AW:0]   WordCount;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int wide_pulses = 0;
    logic prev_wr = 1'b0;

    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    int            log_cyc[$];
    int            fourth_start[$];

    imem_uart_loader #(.CLKS_PER_BIT(C), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Reset(Reset), .RxD(RxD), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .Loading(Loading), .Done(Done), .FrameErr(FrameErr),
        .LenErr(LenErr), .WordCount(WordCount)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (WrEn) begin
            log_addr.push_back(WrAddr);
            log_data.push_back(WrData);
            log_cyc.push_back(cyc);
            if (prev_wr) wide_pulses++;
        end
        prev_wr = WrEn;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        RxD = 1'b1;
        idle(3);
        Reset = 1'b0;
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        fourth_start.delete();
        wide_pulses = 0;
        idle(5);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            idle(C);
        end
        RxD = stop_bit;
        idle(C);
        RxD = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        fourth_start.push_back(cyc);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic test_reset();
        reset_dut();
        idle(200);
        tests_run++; if (WrEn !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wren: got %b expected 0", WrEn); end
        tests_run++; if (WrAddr !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_wraddr: got %0d expected 0", WrAddr); end
        tests_run++; if (WrData !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_wrdata: got %h expected 0", WrData); end
        tests_run++; if (Loading !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_loading: got %b expected 1", Loading); end
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
        tests_run++; if (FrameErr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frameerr: got %b expected 0", FrameErr); end
        tests_run++; if (LenErr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_lenerr: got %b expected 0", LenErr); end
        tests_run++; if (WordCount !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_wordcount: got %0d expected 0", WordCount); end
        tests_run++; if (log_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL reset_no_writes: got %0d writes expected 0", log_addr.size()); end
    endtask

    task automatic test_two_words();
        logic [31:0] exp_data[2];
        exp_data[0] = 32'h12345678;
        exp_data[1] = 32'hDEADBEEF;
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        idle(4);
        tests_run++;
        if (log_addr.size() != 2) begin
            tests_failed++; $display("[TB] FAIL two_words_count: got %0d writes expected 2", log_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++; if (log_addr[i] !== 3'(i)) begin tests_failed++; $display("[TB] FAIL two_words_addr%0d: got %0d expected %0d", i, log_addr[i], i); end
                tests_run++; if (log_data[i] !== exp_data[i]) begin tests_failed++; $display("[TB] FAIL two_words_data%0d: got %h expected %h", i, log_data[i], exp_data[i]); end
                tests_run++; if (log_cyc[i] - fourth_start[i] != WR_LAT) begin tests_failed++; $display("[TB] FAIL two_words_latency%0d: got %0d expected %0d", i, log_cyc[i] - fourth_start[i], WR_LAT); end
            end
        end
        tests_run++; if (wide_pulses != 0) begin tests_failed++; $display("[TB] FAIL two_words_pulse_width: got %0d extra high cycles expected 0", wide_pulses); end
        tests_run++; if (WordCount !== 4'd2) begin tests_failed++; $display("[TB] FAIL two_words_wordcount: got %0d expected 2", WordCount); end
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL two_words_done: got %b expected 1", Done); end
        tests_run++; if (Loading !== 1'b0) begin tests_failed++; $display("[TB] FAIL two_words_loading: got %b expected 0", Loading); end
        send_word(32'hFFFFFFFF);
        idle(4);
        tests_run++; if (log_addr.size() != 2) begin tests_failed++; $display("[TB] FAIL done_ignores_rx: got %0d writes expected 2", log_addr.size()); end
    endtask

    task automatic test_zero_len();
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_len_done: got %b expected 1", Done); end
        tests_run++; if (Loading !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_len_loading: got %b expected 0", Loading); end
        tests_run++; if (log_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL zero_len_writes: got %0d expected 0", log_addr.size()); end
    endtask

    task automatic test_full_and_overflow();
        logic [31:0] w;
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        for (int i = 0; i < 8; i++) begin
            w = 32'h11111111 * (i + 1);
            send_word(w);
        end
        idle(4);
        tests_run++;
        if (log_addr.size() != 8) begin
            tests_failed++; $display("[TB] FAIL full_count: got %0d writes expected 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                w = 32'h11111111 * (i + 1);
                tests_run++; if (log_addr[i] !== 3'(i)) begin tests_failed++; $display("[TB] FAIL full_addr%0d: got %0d expected %0d", i, log_addr[i], i); end
                tests_run++; if (log_data[i] !== w) begin tests_failed++; $display("[TB] FAIL full_data%0d: got %h expected %h", i, log_data[i], w); end
            end
        end
        tests_run++; if (WordCount !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_wordcount: got %0d expected 8", WordCount); end
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_done: got %b expected 1", Done); end

        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h09, 1'b1);
        send_word(32'hA5A5A5A5);
        send_word(32'h5A5A5A5A);
        idle(4);
        tests_run++; if (LenErr !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_lenerr: got %b expected 1", LenErr); end
        tests_run++; if (Loading !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_loading: got %b expected 1", Loading); end
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow_done: got %b expected 0", Done); end
        tests_run++; if (log_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL overflow_writes: got %0d expected 0", log_addr.size()); end
    endtask

    task automatic test_frame_err();
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(40);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(4);
        tests_run++; if (FrameErr !== 1'b1) begin tests_failed++; $display("[TB] FAIL frame_flag: got %b expected 1", FrameErr); end
        tests_run++; if (Loading !== 1'b1) begin tests_failed++; $display("[TB] FAIL frame_loading: got %b expected 1", Loading); end
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_done: got %b expected 0", Done); end
        tests_run++; if (log_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL frame_writes: got %0d expected 0", log_addr.size()); end
        reset_dut();
        tests_run++; if (FrameErr !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_cleared: got %b expected 0", FrameErr); end
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'hCAFEF00D);
        idle(4);
        tests_run++;
        if (log_addr.size() != 1) begin
            tests_failed++; $display("[TB] FAIL frame_reload_count: got %0d writes expected 1", log_addr.size());
        end else begin
            tests_run++; if (log_data[0] !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL frame_reload_data: got %h expected cafef00d", log_data[0]); end
        end
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL frame_reload_done: got %b expected 1", Done); end
    endtask

    task automatic test_glitch();
        reset_dut();
        RxD = 1'b0;
        idle(4);
        RxD = 1'b1;
        idle(60);
        tests_run++; if (FrameErr !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch_frameerr: got %b expected 0", FrameErr); end
        tests_run++; if (Loading !== 1'b1) begin tests_failed++; $display("[TB] FAIL glitch_loading: got %b expected 1", Loading); end
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h0F1E2D3C);
        idle(4);
        tests_run++;
        if (log_addr.size() != 1) begin
            tests_failed++; $display("[TB] FAIL glitch_count: got %0d writes expected 1", log_addr.size());
        end else begin
            tests_run++; if (log_data[0] !== 32'h0F1E2D3C) begin tests_failed++; $display("[TB] FAIL glitch_data: got %h expected 0f1e2d3c", log_data[0]); end
        end
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL glitch_done: got %b expected 1", Done); end
    endtask

    task automatic test_reset_mid_word();
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        reset_dut();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h0BADC0DE);
        idle(4);
        tests_run++;
        if (log_addr.size() != 1) begin
            tests_failed++; $display("[TB] FAIL midreset_count: got %0d writes expected 1", log_addr.size());
        end else begin
            tests_run++; if (log_addr[0] !== 3'd0) begin tests_failed++; $display("[TB] FAIL midreset_addr: got %0d expected 0", log_addr[0]); end
            tests_run++; if (log_data[0] !== 32'h0BADC0DE) begin tests_failed++; $display("[TB] FAIL midreset_data: got %h expected 0badc0de", log_data[0]); end
        end
        tests_run++; if (WordCount !== 4'd1) begin tests_failed++; $display("[TB] FAIL midreset_wordcount: got %0d expected 1", WordCount); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_full_and_overflow();
        test_frame_err();
        test_glitch();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
